// File: rtl/ofu_pkg.sv
// Shared types and sizing helpers for the operand fetch unit.
// Pure declarations: no latency or backpressure of its own.
package ofu_pkg;

   localparam int OFU_DATA_WIDTH = 32;
   localparam int OFU_ADDR_WIDTH = 16;
   localparam int OFU_MEM_LAT    = 2;
   localparam int OFU_FIFO_DEPTH = 8;
   localparam int OFU_WIN_WIDTH  = 16;

   // One SRAM read result pair as it travels to the PE array.
   typedef struct packed {
      logic [OFU_DATA_WIDTH-1:0] ifm;
      logic [OFU_DATA_WIDTH-1:0] flt;
      logic                      last;
   } ofu_pair_t;

   // Pointer width for a power-of-two storage array.
   function automatic int ofu_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of a counter that must be able to hold the value max_val.
   function automatic int ofu_cnt_w(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/ofu_pair_fifo.sv
// Synchronous FIFO of ofu_pair_t with full/empty/count status.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none of its own; the producer must never push while full.
module ofu_pair_fifo
   import ofu_pkg::*;
#(
   parameter int DEPTH = OFU_FIFO_DEPTH,
   localparam int PTR_W = ofu_ptr_w(DEPTH),
   localparam int CNT_W = ofu_cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  ofu_pair_t        wr_data,
   input  logic             pop,
   output ofu_pair_t        rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   ofu_pair_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
      else $error("ofu_pair_fifo: push while full");

endmodule

// File: rtl/operand_fetch_unit.sv
// Issues paired IFM/filter SRAM reads and streams the returned pairs to the PE array; OFU_PERF_CNT_EN adds stall/bubble counters.
// Latency: 0-cycle issue, pair at op_* MEM_LAT+1 cycles after acceptance, 1 pair/cycle sustained.
// Backpressure: credit-based addr_ready (FIFO occupancy + reads in flight < FIFO_DEPTH); refused requests are dropped and flagged.
module operand_fetch_unit
   import ofu_pkg::*;
#(
   parameter int DATA_WIDTH = OFU_DATA_WIDTH,  // must equal OFU_DATA_WIDTH, which sizes ofu_pair_t
   parameter int ADDR_WIDTH = OFU_ADDR_WIDTH,
   parameter int MEM_LAT    = OFU_MEM_LAT,
   parameter int FIFO_DEPTH = OFU_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  addr_valid,
   output logic                  addr_ready,
   input  logic [31:0]           addr_ifm,
   input  logic [31:0]           addr_filter,
   input  logic [15:0]           win_len,
   output logic                  ifm_rd_en,
   output logic [ADDR_WIDTH-1:0] ifm_rd_addr,
   input  logic [DATA_WIDTH-1:0] ifm_rd_data,
   output logic                  flt_rd_en,
   output logic [ADDR_WIDTH-1:0] flt_rd_addr,
   input  logic [DATA_WIDTH-1:0] flt_rd_data,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_WIDTH-1:0] op_ifm,
   output logic [DATA_WIDTH-1:0] op_filter,
   output logic                  op_last,
   output logic                  drop_err,
   output logic                  busy
`ifdef OFU_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           bubble_cnt
`endif
);

   localparam int INF_W = ofu_cnt_w(MEM_LAT);
   localparam int CNT_W = ofu_cnt_w(FIFO_DEPTH);
   localparam int SUM_W = ofu_cnt_w(FIFO_DEPTH + MEM_LAT);
   localparam int WIN_W = OFU_WIN_WIDTH;

   logic               active;
   logic               accept;
   logic [MEM_LAT-1:0] lat_sr;
   logic [INF_W-1:0]   inflight;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_empty;
   logic               fifo_full_unused;
   logic               push;
   logic               pop;
   logic               last_hit;
   ofu_pair_t          push_pair;
   ofu_pair_t          head_pair;
   logic [WIN_W-1:0]   win_cnt;
   logic [WIN_W-1:0]   win_len_q;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^{addr_ifm[31:ADDR_WIDTH+2], addr_ifm[1:0],
                               addr_filter[31:ADDR_WIDTH+2], addr_filter[1:0]};

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) begin
         inflight = inflight + INF_W'(lat_sr[i]);
      end
   end

   // active holds addr_ready low while reset is asserted and for the first cycle after release.
   assign addr_ready  = active &&
                        ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
   assign accept      = addr_valid && addr_ready;
   assign ifm_rd_en   = accept;
   assign flt_rd_en   = accept;
   assign ifm_rd_addr = accept ? addr_ifm[ADDR_WIDTH+1:2]    : '0;
   assign flt_rd_addr = accept ? addr_filter[ADDR_WIDTH+1:2] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         lat_sr <= '0;
      end else begin
         active <= 1'b1;
         lat_sr <= (lat_sr << 1) | MEM_LAT'(accept);
      end
   end

   // The tail bit lines up with the SRAM data for the read issued MEM_LAT cycles ago.
   assign push     = lat_sr[MEM_LAT-1];
   assign last_hit = (win_cnt == (win_len_q - WIN_W'(1)));

   always_comb begin
      push_pair      = '0;
      push_pair.ifm  = ifm_rd_data;
      push_pair.flt  = flt_rd_data;
      push_pair.last = last_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt   <= '0;
         win_len_q <= WIN_W'(1);
      end else begin
         if (!busy) begin
            win_len_q <= (win_len == '0) ? WIN_W'(1) : win_len;
         end
         if (push) begin
            win_cnt <= last_hit ? '0 : win_cnt + WIN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_err <= 1'b0;
      end else if (addr_valid && !addr_ready) begin
         drop_err <= 1'b1;
      end
   end

   ofu_pair_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_pair_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (push_pair),
      .pop     (pop),
      .rd_data (head_pair),
      .full    (fifo_full_unused),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign op_valid  = !fifo_empty;
   assign pop       = op_valid && op_ready;
   assign op_ifm    = fifo_empty ? '0   : head_pair.ifm;
   assign op_filter = fifo_empty ? '0   : head_pair.flt;
   assign op_last   = fifo_empty ? 1'b0 : head_pair.last;
   assign busy      = (inflight != '0) || !fifo_empty;

`ifdef OFU_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (addr_valid && !addr_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (op_ready && !op_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit with a fixed-latency SRAM model.
module tb_operand_fetch_unit;

   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int LAT   = 2;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          addr_valid;
   logic          addr_ready;
   logic [31:0]   addr_ifm;
   logic [31:0]   addr_filter;
   logic [15:0]   win_len;
   logic          ifm_rd_en;
   logic [AW-1:0] ifm_rd_addr;
   logic [DW-1:0] ifm_rd_data;
   logic          flt_rd_en;
   logic [AW-1:0] flt_rd_addr;
   logic [DW-1:0] flt_rd_data;
   logic          op_valid;
   logic          op_ready;
   logic [DW-1:0] op_ifm;
   logic [DW-1:0] op_filter;
   logic          op_last;
   logic          drop_err;
   logic          busy;
`ifdef OFU_PERF_CNT_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   bubble_cnt;
`endif

   always #5 clk = ~clk;

   operand_fetch_unit #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_LAT    (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .addr_valid  (addr_valid),
      .addr_ready  (addr_ready),
      .addr_ifm    (addr_ifm),
      .addr_filter (addr_filter),
      .win_len     (win_len),
      .ifm_rd_en   (ifm_rd_en),
      .ifm_rd_addr (ifm_rd_addr),
      .ifm_rd_data (ifm_rd_data),
      .flt_rd_en   (flt_rd_en),
      .flt_rd_addr (flt_rd_addr),
      .flt_rd_data (flt_rd_data),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_ifm      (op_ifm),
      .op_filter   (op_filter),
      .op_last     (op_last),
      .drop_err    (drop_err),
      .busy        (busy)
`ifdef OFU_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt),
      .bubble_cnt  (bubble_cnt)
`endif
   );

   function automatic logic [31:0] ifm_word(input logic [15:0] a);
      return {16'hA1F0, a};
   endfunction

   function automatic logic [31:0] flt_word(input logic [15:0] a);
      return {a ^ 16'h5A5A, 16'hF17E};
   endfunction

   // SRAM model: data for a read strobed in cycle t is presented during cycle t+LAT.
   logic [DW-1:0] ifm_pipe [LAT];
   logic [DW-1:0] flt_pipe [LAT];
   always @(posedge clk) begin
      ifm_pipe[0] <= ifm_rd_en ? ifm_word(ifm_rd_addr) : 32'hDEAD_0000;
      flt_pipe[0] <= flt_rd_en ? flt_word(flt_rd_addr) : 32'hDEAD_1111;
      for (int i = 1; i < LAT; i++) begin
         ifm_pipe[i] <= ifm_pipe[i-1];
         flt_pipe[i] <= flt_pipe[i-1];
      end
   end
   assign ifm_rd_data = ifm_pipe[LAT-1];
   assign flt_rd_data = flt_pipe[LAT-1];

   typedef struct packed {
      logic [31:0] ifm;
      logic [31:0] flt;
      logic        last;
   } exp_t;

   exp_t        sb [$];
   exp_t        push_e;
   exp_t        pop_e;
   int          n_checks  = 0;
   int          n_fail    = 0;
   int          n_pops    = 0;
   int          n_lasts   = 0;
   int          win_len_m = 4;
   int          win_cnt_m = 0;
   logic [31:0] next_word = 32'd0;

   // Expected pairs are queued on acceptance and compared when the PE side takes them.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (addr_valid && addr_ready) begin
            push_e.ifm  = ifm_word(addr_ifm[17:2]);
            push_e.flt  = flt_word(addr_filter[17:2]);
            push_e.last = (win_cnt_m == win_len_m - 1);
            win_cnt_m   = push_e.last ? 0 : win_cnt_m + 1;
            sb.push_back(push_e);
            next_word   = next_word + 32'd1;
         end
         if (op_valid && op_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: op_valid with nothing expected, got ifm=%h flt=%h", op_ifm, op_filter);
            end else begin
               pop_e = sb.pop_front();
               n_pops++;
               if (op_last) n_lasts++;
               if ({op_ifm, op_filter, op_last} !== pop_e) begin
                  n_fail++;
                  $display("FAIL sb_pair: got ifm=%h flt=%h last=%b, expected ifm=%h flt=%h last=%b",
                           op_ifm, op_filter, op_last, pop_e.ifm, pop_e.flt, pop_e.last);
               end
            end
         end
      end
   end

   task automatic cycle_start();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit v);
      addr_valid  = v;
      addr_ifm    = next_word << 2;
      addr_filter = (next_word + 32'h100) << 2;
   endtask

   task automatic drain(output bit ok);
      ok       = 1'b0;
      op_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      cycle_start();
      op_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      op_ready = 1'b1;
      win_len  = 16'd4;
      set_req(1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({addr_ready, ifm_rd_en, flt_rd_en, op_valid, op_last, drop_err, busy} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {addr_ready, ifm_rd_en, flt_rd_en, op_valid, op_last, drop_err, busy});
      end
      n_checks++;
      if ({ifm_rd_addr, flt_rd_addr} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h %h expected 0 0", ifm_rd_addr, flt_rd_addr);
      end
      n_checks++;
      if ({op_ifm, op_filter} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h expected 0 0", op_ifm, op_filter);
      end
      cycle_start();
      set_req(1'b0);
      op_ready = 1'b0;
      rst_n    = 1'b1;
      repeat (2) cycle_start();
      @(negedge clk);
      n_checks++;
      if (addr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b expected 1", addr_ready);
      end
   endtask

   task automatic test_streaming();
      int pops0;
      int lasts0;
      bit ok;
      win_len   = 16'd4;
      win_len_m = 4;
      cycle_start();
      pops0    = n_pops;
      lasts0   = n_lasts;
      op_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle_start();
         set_req(1'b1);
         @(negedge clk);
         n_checks++;
         if ({ifm_rd_en, flt_rd_en, ifm_rd_addr, flt_rd_addr} !== {2'b11, AW'(k), AW'(16'h100 + k)}) begin
            n_fail++;
            $display("FAIL stream_issue[%0d]: got en=%b%b addr=%h/%h expected en=11 addr=%h/%h",
                     k, ifm_rd_en, flt_rd_en, ifm_rd_addr, flt_rd_addr, AW'(k), AW'(16'h100 + k));
         end
         n_checks++;
         if (op_valid !== (k >= 3)) begin
            n_fail++;
            $display("FAIL stream_valid_timing[%0d]: got %b expected %b", k, op_valid, (k >= 3));
         end
      end
      cycle_start();
      set_req(1'b0);
      drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL stream_drain: got timeout expected idle");
      end
      n_checks++;
      if ((n_pops - pops0) != 8 || (n_lasts - lasts0) != 2 || drop_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_counts: got pops=%0d lasts=%0d drop=%b expected 8 2 0",
                  n_pops - pops0, n_lasts - lasts0, drop_err);
      end
   endtask

   task automatic test_drop();
      int acc;
      bit ok;
      acc      = 0;
      op_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle_start();
         set_req(1'b1);
         @(negedge clk);
         if (ifm_rd_en) acc++;
      end
      cycle_start();
      set_req(1'b0);
      @(negedge clk);
      n_checks++;
      if (acc != 8 || addr_ready !== 1'b0 || drop_err !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_fill: got acc=%0d ready=%b drop=%b expected 8 0 0", acc, addr_ready, drop_err);
      end
      cycle_start();
      set_req(1'b1);
      @(negedge clk);
      n_checks++;
      if ({ifm_rd_en, flt_rd_en, addr_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL drop_no_read: got en=%b%b ready=%b expected 000", ifm_rd_en, flt_rd_en, addr_ready);
      end
      cycle_start();
      set_req(1'b0);
      @(negedge clk);
      n_checks++;
      if (drop_err !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_flag: got %b expected 1", drop_err);
      end
      drain(ok);
      repeat (3) cycle_start();
      @(negedge clk);
      n_checks++;
      if (!ok || drop_err !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_sticky: got drained=%b drop=%b expected 1 1", ok, drop_err);
      end
   endtask

   task automatic test_backpressure();
      int acc;
      int vcyc;
      int pops0;
      int lasts0;
      bit ok;
      win_len   = 16'd3;
      win_len_m = 3;
      op_ready  = 1'b0;
      cycle_start();
      acc    = 0;
      pops0  = n_pops;
      lasts0 = n_lasts;
      for (int c = 0; c < 14; c++) begin
         cycle_start();
         set_req(1'b1);
         @(negedge clk);
         if (addr_valid && addr_ready) acc++;
      end
      n_checks++;
      if (acc != 8 || addr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_credits: got accepted=%0d ready=%b expected 8 0", acc, addr_ready);
      end
      cycle_start();
      set_req(1'b0);
      op_ready = 1'b1;
      vcyc     = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (op_valid) vcyc++;
      end
      @(negedge clk);
      n_checks++;
      if (vcyc != 8 || op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_throughput: got valid_cycles=%0d then valid=%b expected 8 then 0", vcyc, op_valid);
      end
      drain(ok);
      n_checks++;
      if (!ok || (n_pops - pops0) != 8 || (n_lasts - lasts0) != 2) begin
         n_fail++;
         $display("FAIL bp_counts: got drained=%b pops=%0d lasts=%0d expected 1 8 2",
                  ok, n_pops - pops0, n_lasts - lasts0);
      end
   endtask

   task automatic test_push_pop_full();
      bit ok;
      op_ready = 1'b0;
      for (int k = 0; k < DEPTH - 1; k++) begin
         cycle_start();
         set_req(1'b1);
      end
      cycle_start();
      set_req(1'b0);
      repeat (LAT + 1) cycle_start();
      set_req(1'b1);
      @(negedge clk);
      n_checks++;
      if ({addr_ready, ifm_rd_en} !== 2'b11) begin
         n_fail++;
         $display("FAIL pp_last_credit: got ready=%b en=%b expected 1 1", addr_ready, ifm_rd_en);
      end
      cycle_start();
      set_req(1'b0);
      @(negedge clk);
      n_checks++;
      if (addr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL pp_no_credit: got %b expected 0", addr_ready);
      end
      cycle_start();
      op_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (op_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pp_pop_valid: got %b expected 1", op_valid);
      end
      cycle_start();
      op_ready = 1'b0;
      set_req(1'b1);
      @(negedge clk);
      n_checks++;
      if ({addr_ready, ifm_rd_en} !== 2'b11) begin
         n_fail++;
         $display("FAIL pp_after_swap: got ready=%b en=%b expected 1 1", addr_ready, ifm_rd_en);
      end
      cycle_start();
      set_req(1'b0);
      @(negedge clk);
      n_checks++;
      if (addr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL pp_count_kept: got ready=%b expected 0", addr_ready);
      end
      drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pp_drain: got timeout expected idle");
      end
   endtask

   task automatic test_reset_mid_stream();
      int seen;
      op_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle_start();
         set_req(1'b1);
      end
      cycle_start();
      set_req(1'b0);
      rst_n     = 1'b0;
      sb.delete();
      win_cnt_m = 0;
      #1;
      n_checks++;
      if ({op_valid, busy, drop_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_mid_clear: got valid=%b busy=%b drop=%b expected 000", op_valid, busy, drop_err);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      op_ready = 1'b1;
      seen     = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (op_valid || busy) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL rst_mid_stale: got %0d cycles with valid/busy expected 0", seen);
      end
      cycle_start();
      op_ready = 1'b0;
   endtask

   task automatic test_win_len_zero();
      int pops0;
      int lasts0;
      bit ok;
      win_len   = 16'd0;
      win_len_m = 1;
      cycle_start();
      pops0    = n_pops;
      lasts0   = n_lasts;
      op_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle_start();
         set_req(1'b1);
      end
      cycle_start();
      set_req(1'b0);
      drain(ok);
      n_checks++;
      if (!ok || (n_pops - pops0) != 3 || (n_lasts - lasts0) != 3) begin
         n_fail++;
         $display("FAIL win_zero: got drained=%b pops=%0d lasts=%0d expected 1 3 3",
                  ok, n_pops - pops0, n_lasts - lasts0);
      end
   endtask

`ifdef OFU_PERF_CNT_EN
   task automatic test_perf_counters();
      rst_n     = 1'b0;
      op_ready  = 1'b0;
      set_req(1'b0);
      sb.delete();
      win_cnt_m = 0;
      repeat (2) cycle_start();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle_start();
         set_req(1'b1);
      end
      for (int k = 0; k < 5; k++) begin
         cycle_start();
         set_req(1'b1);
      end
      cycle_start();
      set_req(1'b0);
      @(negedge clk);
      n_checks++;
      if (stall_cnt !== 32'd5) begin
         n_fail++;
         $display("FAIL perf_stall: got %0d expected 5", stall_cnt);
      end
      cycle_start();
      op_ready = 1'b1;
      repeat (11) cycle_start();
      op_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bubble_cnt !== 32'd3 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL perf_bubble: got %0d (left %0d) expected 3 (left 0)", bubble_cnt, sb.size());
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_drop();
      test_backpressure();
      test_push_pop_full();
      test_reset_mid_stream();
      test_win_len_zero();
`ifdef OFU_PERF_CNT_EN
      test_perf_counters();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
